// File: rtl/encoder_4x2_buffered.sv
// Registered 4-to-2 priority encoder: request edges are buffered in a pending
// register and presented one code at a time (highest index first) with a V/ACK handshake.
module encoder_4x2_buffered (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] R,
    input  logic       E,
    input  logic       ACK,
    output logic [1:0] A,
    output logic       V,
    output logic [3:0] P,
    output logic       OVF
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] rq_q, rq_d;
    logic [3:0] p_q, p_d;
    logic [1:0] a_q, a_d;
    logic       ovf_q, ovf_d;

    logic [3:0] rise;
    logic [3:0] cap;
    logic [3:0] grant;
    logic [1:0] sel_idx;
    logic       load;

    always_comb begin
        rise = R & ~rq_q;
        cap  = E ? rise : '0;
        rq_d = R;

        sel_idx = 2'd0;
        if (p_q[3]) begin
            sel_idx = 2'd3;
        end else if (p_q[2]) begin
            sel_idx = 2'd2;
        end else if (p_q[1]) begin
            sel_idx = 2'd1;
        end

        // A new code is taken only from registered P, when idle or on an accepted ACK.
        load  = (p_q != '0) && ((state_q == IDLE) || ACK);
        grant = load ? (4'b0001 << sel_idx) : '0;

        state_d = state_q;
        a_d     = a_q;
        if (load) begin
            state_d = HOLD;
            a_d     = sel_idx;
        end else if ((state_q == HOLD) && ACK) begin
            state_d = IDLE;
        end

        // Capture is OR-ed after the clear so a re-request of the granted bit survives.
        p_d   = (p_q & ~grant) | cap;
        ovf_d = ovf_q | ((cap & p_q & ~grant) != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rq_q    <= '1;
            p_q     <= '0;
            a_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            p_q     <= p_d;
            a_q     <= a_d;
            ovf_q   <= ovf_d;
        end
    end

    assign A   = a_q;
    assign V   = (state_q == HOLD);
    assign P   = p_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_encoder_4x2_buffered.sv
// Scoreboard bench for encoder_4x2_buffered: a request-set reference model predicts
// the visible state after each edge; a monitor compares it against the outputs.
module tb_encoder_4x2_buffered;

    logic       clk;
    logic       rst_n;
    logic [3:0] R;
    logic       E;
    logic       ACK;
    logic [1:0] A;
    logic       V;
    logic [3:0] P;
    logic       OVF;

    encoder_4x2_buffered dut (
        .clk  (clk),
        .rst_n(rst_n),
        .R    (R),
        .E    (E),
        .ACK  (ACK),
        .A    (A),
        .V    (V),
        .P    (P),
        .OVF  (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] a;
        logic       v;
        logic [3:0] p;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: a set of waiting requests, the code on show, and line history.
    bit m_wait[4];
    bit m_prev[4];
    int m_cur;
    bit m_valid;
    bit m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_wait[i] = 1'b0;
            m_prev[i] = 1'b1;
        end
        m_cur   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic e,
                                       input logic ack, input logic rst);
        bit req[4];
        int best;
        bit free;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            req[i]    = e && r[i] && !m_prev[i];
            m_prev[i] = r[i];
        end
        best = -1;
        for (int i = 0; i < 4; i++)
            if (m_wait[i]) best = i;
        free = !m_valid || ack;
        if (!free) best = -1;
        if (free && best < 0) m_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            if (req[i] && m_wait[i] && i != best) m_ovf = 1'b1;
        if (best >= 0) begin
            m_wait[best] = 1'b0;
            m_cur        = best;
            m_valid      = 1'b1;
        end
        for (int i = 0; i < 4; i++)
            if (req[i]) m_wait[i] = 1'b1;
    endfunction

    function automatic exp_t model_snapshot();
        exp_t s;
        s.a = 2'(m_cur);
        s.v = m_valid;
        for (int i = 0; i < 4; i++) s.p[i] = m_wait[i];
        s.ovf = m_ovf;
        return s;
    endfunction

    task automatic cycle(input logic [3:0] r, input logic e, input logic ack, input logic rst);
        @(negedge clk);
        R     = r;
        E     = e;
        ACK   = ack;
        rst_n = rst;
        model_step(r, e, ack, rst);
        exp_q.push_back(model_snapshot());
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                checks++;
                if (A !== x.a) begin
                    errors++;
                    $display("FAIL A cycle %0d got %b want %b", cyc, A, x.a);
                end
                checks++;
                if (V !== x.v) begin
                    errors++;
                    $display("FAIL V cycle %0d got %b want %b", cyc, V, x.v);
                end
                checks++;
                if (P !== x.p) begin
                    errors++;
                    $display("FAIL P cycle %0d got %b want %b", cyc, P, x.p);
                end
                checks++;
                if (OVF !== x.ovf) begin
                    errors++;
                    $display("FAIL OVF cycle %0d got %b want %b", cyc, OVF, x.ovf);
                end
            end
        end
    end

    initial begin : driver
        int budget;
        rst_n = 1'b0;
        R     = '0;
        E     = 1'b1;
        ACK   = 1'b0;
        model_reset();

        // Reset, single request, hold, acknowledge
        cycle(4'b0000, 1, 0, 0);
        cycle(4'b0000, 1, 0, 0);
        cycle(4'b0000, 1, 0, 1);
        cycle(4'b0001, 1, 0, 1);
        cycle(4'b0001, 1, 0, 1);
        cycle(4'b0001, 1, 0, 1);
        cycle(4'b0001, 1, 1, 1);
        cycle(4'b0000, 1, 0, 1);

        // Simultaneous requests drained back-to-back with ACK held
        cycle(4'b1011, 1, 1, 1);
        repeat (5) cycle(4'b1011, 1, 1, 1);
        cycle(4'b0000, 1, 0, 1);

        // Overtake: code 0 on show, higher request queues behind it
        cycle(4'b0001, 1, 0, 1);
        cycle(4'b0001, 1, 0, 1);
        cycle(4'b0101, 1, 0, 1);
        cycle(4'b0101, 1, 0, 1);
        cycle(4'b0101, 1, 1, 1);
        cycle(4'b0000, 1, 1, 1);
        cycle(4'b0000, 1, 0, 1);

        // Overflow: R[1] rises twice while pending behind code 0
        cycle(4'b0001, 1, 0, 1);
        cycle(4'b0000, 1, 0, 1);
        cycle(4'b0010, 1, 0, 1);
        cycle(4'b0000, 1, 0, 1);
        cycle(4'b0010, 1, 0, 1);
        cycle(4'b0000, 1, 1, 1);
        cycle(4'b0000, 1, 1, 1);
        cycle(4'b0000, 1, 0, 1);

        // Gating: edge dropped with E=0, level with E=1 is not a request
        cycle(4'b1000, 0, 0, 1);
        cycle(4'b1000, 0, 0, 1);
        cycle(4'b1000, 1, 0, 1);
        cycle(4'b1000, 1, 0, 1);
        cycle(4'b0000, 1, 0, 1);

        // Grant/capture collision on bit 0
        cycle(4'b0100, 1, 0, 1);
        cycle(4'b0101, 1, 0, 1);
        cycle(4'b0100, 1, 0, 1);
        cycle(4'b0101, 1, 1, 1);
        cycle(4'b0000, 1, 0, 1);
        cycle(4'b0000, 1, 1, 1);
        cycle(4'b0000, 1, 1, 1);

        // Reset mid-operation with lines held high through release
        cycle(4'b1000, 1, 0, 1);
        cycle(4'b1110, 1, 0, 1);
        cycle(4'b1110, 1, 0, 0);
        cycle(4'b1110, 1, 0, 1);
        cycle(4'b1110, 1, 0, 1);
        cycle(4'b0000, 1, 0, 1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            cycle(4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 60) != 0);
        end

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
